// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// serial line levels and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Payloads narrower than 16 bits are zero-extended by the caller,
    // which leaves the XOR reduction unchanged.
    function automatic logic calc_parity(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Four-entry input FIFO placed ahead of the serialiser when UART_TX_FIFO_EN is defined.
// Pointers are 2 index bits plus a wrap bit, so full and empty can be told apart.
module uart_tx_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    logic [2:0]       wr_ptr;
    logic [2:0]       rd_ptr;
    logic [WIDTH-1:0] mem [4];
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[2] != rd_ptr[2]) && (wr_ptr[1:0] == rd_ptr[1:0]);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr[1:0]];

    // Pointer update; a pop in the same cycle frees the slot a push into a full FIFO needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_WIDTH data bits LSB first,
// optional parity, one or two stop bits, runtime prescaler, valid/ready handshake
// and zero-gap back-to-back frames.
// Optional feature: define UART_TX_FIFO_EN to insert a 4-entry input FIFO.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  Data_Ready,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int IDX_W = 4;

    uart_tx_state_t state;
    uart_tx_state_t next_state;

    logic [PRESCALE_W-1:0] cnt;
    logic [PRESCALE_W-1:0] cnt_next;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] prescale_eff;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      bit_idx_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] word_in;
    logic [15:0]           data_ext;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  stop2_q;
    logic                  bit_done;
    logic                  last_stop;
    logic                  ser_ready;
    logic                  xfer;
    logic                  tx_out_d;
    logic                  busy_d;

    assign bit_done     = (cnt == '0);
    assign last_stop    = (state == STOP) && bit_done && (!stop2_q || (bit_idx == IDX_W'(1)));
    assign ser_ready    = (state == IDLE) || last_stop;
    assign prescale_eff = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;

`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic fifo_push;

    assign fifo_pop   = ser_ready && !fifo_empty && !RST;
    assign xfer       = fifo_pop;
    assign Data_Ready = !RST && (!fifo_full || fifo_pop);
    assign fifo_push  = Data_Valid && Data_Ready;

    uart_tx_fifo #(
        .WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (fifo_push),
        .push_data (P_DATA),
        .pop       (fifo_pop),
        .head_data (word_in),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
`else
    assign Data_Ready = ser_ready && !RST;
    assign xfer       = Data_Valid && Data_Ready;
    assign word_in    = P_DATA;
`endif

    // State register together with the registered line and busy outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            TX_OUT <= IDLE_LEVEL;
            busy   <= 1'b0;
        end else begin
            state  <= next_state;
            TX_OUT <= tx_out_d;
            busy   <= busy_d;
        end
    end

    // Next-state logic; every non-idle state advances only when its bit period ends.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (xfer) next_state = START;
            end
            START: begin
                if (bit_done) next_state = DATA;
            end
            DATA: begin
                if (bit_done && (bit_idx == IDX_W'(DATA_WIDTH - 1))) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) next_state = STOP;
            end
            STOP: begin
                if (last_stop) next_state = xfer ? START : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counter next values: reload at every bit boundary, bit index restarts on a state change.
    always_comb begin
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        if (xfer) begin
            cnt_next     = prescale_eff - PRESCALE_W'(1);
            bit_idx_next = '0;
        end else if (state != IDLE) begin
            if (bit_done) begin
                cnt_next     = prescale_q - PRESCALE_W'(1);
                bit_idx_next = (next_state == state) ? (bit_idx + IDX_W'(1)) : '0;
            end else begin
                cnt_next = cnt - PRESCALE_W'(1);
            end
        end
    end

    // Zero-extend the latched word so it can be indexed and reduced at a fixed width.
    always_comb begin
        data_ext                   = '0;
        data_ext[DATA_WIDTH-1:0]   = data_q;
    end

    // Output decode from the upcoming state, so the line is registered with no input path.
    always_comb begin
        busy_d   = (next_state != IDLE);
        tx_out_d = IDLE_LEVEL;
        case (next_state)
            START:   tx_out_d = START_LEVEL;
            DATA:    tx_out_d = data_ext[bit_idx_next];
            PARITY:  tx_out_d = calc_parity(data_ext, par_typ_q);
            default: tx_out_d = IDLE_LEVEL;
        endcase
    end

    // Bit timing counters and the frame configuration captured at each transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            bit_idx    <= '0;
            prescale_q <= PRESCALE_W'(1);
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            if (xfer) begin
                prescale_q <= prescale_eff;
                data_q     <= word_in;
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                stop2_q    <= STOP2;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: table vectors from known line patterns,
// hand-written back-to-back and mid-frame reset sequences, and random frames
// checked against a bit-list model of the frame format.
module tb_uart_tx_param;

    localparam int DW = 8;
    localparam int PW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Data_Ready;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          STOP2;
    logic [PW-1:0] Prescale;
    logic          TX_OUT;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic        stop2;
        logic [15:0] presc;
    } frame_t;

    typedef struct {
        frame_t f;
        string  pattern;
    } vector_t;

    frame_t  seq[$];
    bit      exp_line[$];
    bit      got[$];
    int      exp_hs[$];
    int      cum;
    vector_t vec[$];

    always #5 CLK = ~CLK;

    uart_tx_param #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Data_Ready (Data_Ready),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic checkLine(input string name);
        string g;
        string e;
        g = "";
        e = "";
        foreach (got[i]) g = $sformatf("%s%0d", g, got[i]);
        foreach (exp_line[i]) e = $sformatf("%s%0d", e, exp_line[i]);
        n_checks++;
        if (g != e) begin
            n_fail++;
            $display("[TB] FAIL %s line: got %s, required %s", name, g, e);
        end
    endtask

    task automatic newSeq();
        seq.delete();
        exp_line.delete();
        exp_hs.delete();
        got.delete();
        cum = 0;
    endtask

    function automatic frame_t mkFrame(input logic [7:0] d, input logic pe, input logic pt,
                                       input logic s2, input logic [15:0] p);
        frame_t f;
        f.data = d; f.par_en = pe; f.par_typ = pt; f.stop2 = s2; f.presc = p;
        return f;
    endfunction

    task automatic addVec(input frame_t f, input string pat);
        vector_t v;
        v.f = f;
        v.pattern = pat;
        vec.push_back(v);
    endtask

    // Reference model: list the frame's bits, then hold each for max(Prescale,1) cycles.
    task automatic appendFrame(input frame_t f, input bit is_last);
        int eff;
        bit bits[$];
        eff = (f.presc == 0) ? 1 : int'(f.presc);
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(f.data[i]);
        if (f.par_en) bits.push_back((($countones(f.data) % 2) == 1) != f.par_typ);
        bits.push_back(1'b1);
        if (f.stop2) bits.push_back(1'b1);
        foreach (bits[i]) repeat (eff) exp_line.push_back(bits[i]);
        cum += bits.size() * eff;
        if (!is_last) exp_hs.push_back(cum - 1);
    endtask

    task automatic expandPattern(input string pat, input frame_t f);
        int eff;
        eff = (f.presc == 0) ? 1 : int'(f.presc);
        for (int i = 0; i < pat.len(); i++) repeat (eff) exp_line.push_back(pat.getc(i) == "1");
    endtask

    task automatic driveFrame(input frame_t f);
        P_DATA = f.data; PAR_EN = f.par_en; PAR_TYP = f.par_typ; STOP2 = f.stop2;
        Prescale = f.presc; Data_Valid = 1'b1;
    endtask

    task automatic scrambleInputs();
        Data_Valid = 1'b0;
        P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        STOP2 = 1'($urandom); Prescale = PW'($urandom_range(0, 7));
    endtask

    // Send every frame of seq with no gap, capturing the line each cycle after the first transfer.
    task automatic applyStimulus(input string name);
        int waited;
        bit busy_ok;
        bit hs;
        int hs_seen[$];
        int next_idx;
        got.delete();
        waited = 0;
        while (Data_Ready !== 1'b1 && waited < 300) begin
            @(posedge CLK); #1;
            waited++;
        end
        checkOutput({name, " ready"}, Data_Ready, 1);
        driveFrame(seq[0]);
        @(posedge CLK); #1;
        next_idx = 1;
        if (seq.size() > 1) driveFrame(seq[1]); else scrambleInputs();
        busy_ok = 1'b1;
        for (int cyc = 0; cyc < exp_line.size(); cyc++) begin
            got.push_back(TX_OUT);
            if (busy !== 1'b1) busy_ok = 1'b0;
            hs = (Data_Valid === 1'b1) && (Data_Ready === 1'b1);
            if (hs) hs_seen.push_back(cyc);
            @(posedge CLK); #1;
            if (hs) begin
                next_idx++;
                if (next_idx < seq.size()) driveFrame(seq[next_idx]); else scrambleInputs();
            end
        end
        Data_Valid = 1'b0;
        checkLine(name);
        checkOutput({name, " busy_through_frame"}, busy_ok, 1);
        checkOutput({name, " handshakes"}, hs_seen.size(), exp_hs.size());
        foreach (exp_hs[i]) if (i < hs_seen.size()) checkOutput({name, " hs_cycle"}, hs_seen[i], exp_hs[i]);
        checkOutput({name, " idle_tx"}, TX_OUT, 1);
        checkOutput({name, " idle_busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frame_t f;
        frame_t f2;
        RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        STOP2 = 1'b0; Prescale = 16'd1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checkOutput("reset_tx", TX_OUT, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ready", Data_Ready, 0);
        RST = 1'b0;
        #1;
        checkOutput("post_reset_ready", Data_Ready, 1);

        // Table of known line patterns (one character per bit period).
        addVec(mkFrame(8'hF8, 1'b0, 1'b0, 1'b0, 16'd1), "0000111111");
        addVec(mkFrame(8'h6F, 1'b1, 1'b0, 1'b0, 16'd1), "01111011001");
        addVec(mkFrame(8'h6F, 1'b1, 1'b1, 1'b0, 16'd1), "01111011011");
        addVec(mkFrame(8'h5D, 1'b0, 1'b0, 1'b1, 16'd4), "01011101011");
        addVec(mkFrame(8'hA5, 1'b0, 1'b0, 1'b0, 16'd0), "0101001011");
        addVec(mkFrame(8'h00, 1'b1, 1'b1, 1'b1, 16'd3), "000000000111");
        foreach (vec[i]) begin
            newSeq();
            seq.push_back(vec[i].f);
            expandPattern(vec[i].pattern, vec[i].f);
            applyStimulus($sformatf("vec%0d", i));
        end

        // Back-to-back frames, second word offered while the first is still on the line.
        newSeq();
        f  = mkFrame(8'h6F, 1'b1, 1'b0, 1'b0, 16'd1);
        f2 = mkFrame(8'h78, 1'b1, 1'b0, 1'b0, 16'd1);
        seq.push_back(f); seq.push_back(f2);
        appendFrame(f, 1'b0); appendFrame(f2, 1'b1);
        applyStimulus("b2b");
        checkOutput("b2b_parity2", got[20], 0);

        // Reset in the middle of the data bits aborts the frame.
        newSeq();
        driveFrame(mkFrame(8'hC3, 1'b0, 1'b0, 1'b0, 16'd2));
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        checkOutput("mid_frame_bit1", TX_OUT, 1);
        checkOutput("mid_frame_busy", busy, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        checkOutput("abort_tx", TX_OUT, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ready_in_reset", Data_Ready, 0);
        RST = 1'b0;
        #1;
        checkOutput("abort_idle_ready", Data_Ready, 1);
        @(posedge CLK); #1;
        checkOutput("abort_no_stop_tx", TX_OUT, 1);
        checkOutput("abort_no_stop_busy", busy, 0);
        newSeq();
        f = mkFrame(8'hC3, 1'b1, 1'b1, 1'b1, 16'd2);
        seq.push_back(f);
        appendFrame(f, 1'b1);
        applyStimulus("after_reset");

        // Random single and back-to-back frames against the model.
        for (int r = 0; r < 8; r++) begin
            int n;
            newSeq();
            n = $urandom_range(1, 2);
            for (int k = 0; k < n; k++) begin
                f = mkFrame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                            16'($urandom_range(0, 5)));
                seq.push_back(f);
                appendFrame(f, k == n - 1);
            end
            applyStimulus($sformatf("rand%0d", r));
        end

`ifdef UART_TX_FIFO_EN
        // Five consecutive pushes: the first pops at once, four more fill the FIFO.
        newSeq();
        exp_line.push_back(1'b1);
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 16'd2;
        for (int i = 0; i < 5; i++) begin
            f = mkFrame(8'($urandom), 1'b0, 1'b0, 1'b0, 16'd2);
            appendFrame(f, i == 4);
            P_DATA = f.data;
            Data_Valid = 1'b1;
            checkOutput($sformatf("fifo_ready%0d", i), Data_Ready, 1);
            @(posedge CLK); #1;
            got.push_back(TX_OUT);
        end
        Data_Valid = 1'b0;
        checkOutput("fifo_full_ready", Data_Ready, 0);
        repeat (100) begin @(posedge CLK); #1; got.push_back(TX_OUT); end
        repeat (4) exp_line.push_back(1'b1);
        checkLine("fifo_order");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised next-generation UART transmitter for the UART_TX subsystem. It serialises a DATA_WIDTH-bit word, LSB first, as one frame: start bit, data, optional parity, then 1 or 2 stop bits.
It adds over the current TX:
- a runtime baud prescaler;
- a valid/ready handshake;
- selectable stop-bit count;
- back-to-back frames with zero idle gap.

Parameters:
DATA_WIDTH, 8, payload bits per frame (legal range 5..9)
PRESCALE_W, 16, width of the Prescale input (clocks-per-bit divider)

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST  in  1  reset, synchronous, active-high
P_DATA  in  DATA_WIDTH  parallel word to transmit
Data_Valid  in  1  P_DATA is valid this cycle
Data_Ready  out  1  block can accept a word this cycle
PAR_EN  in  1  1 = insert parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
STOP2  in  1  1 = two stop bits, 0 = one stop bit
Prescale  in  PRESCALE_W  CLK cycles per bit; 0 is treated as 1
TX_OUT  out  1  serial line; idles high
busy  out  1  high while a frame is on the line

Behaviour:
- Reset (RST=1 at a clock edge): TX_OUT=1, busy=0, Data_Ready=0 during reset, state=IDLE, all counters 0.
  - RST mid-frame aborts the frame: TX_OUT=1 from the next edge; no partial stop bit.
- Handshake:
  - A transfer occurs when Data_Valid && Data_Ready at a rising edge.
  - Data_Ready=1 in IDLE, and in the last CLK cycle of the final stop bit. This enables back-to-back frames.
  - Data_Valid while Data_Ready=0 is ignored; no queueing without the optional feature.
- On a transfer, latch P_DATA, PAR_EN, PAR_TYP, STOP2 and Prescale. Mid-frame input changes have no effect.
- Parity: XOR-reduce the latched data, then XOR with PAR_TYP.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on transfer.
  - START -> DATA.
  - DATA -> DATA for DATA_WIDTH bits (bit index 0..DATA_WIDTH-1). Then -> PARITY if PAR_EN, else -> STOP.
  - PARITY -> STOP.
  - STOP -> STOP for the second stop bit if STOP2.
  - STOP exits to START if a transfer occurs in its last cycle, else to IDLE.
- Bit timing:
  - Each bit is held for exactly max(Prescale,1) CLK cycles.
  - A down-counter of PRESCALE_W bits reloads at every bit boundary.
- Latency: the start bit (TX_OUT=0) appears on the first cycle after the transfer edge (registered output).
- TX_OUT and busy are registered; no combinational path from inputs to TX_OUT.
- busy is high from the START cycle through the last stop cycle.
  - busy stays high across back-to-back frames.
  - busy drops on the first IDLE cycle.
- Frame length in bits: 1 + DATA_WIDTH + PAR_EN + (STOP2 ? 2 : 1).

Optional Feature:
Macro UART_TX_FIFO_EN.
- Defined:
  - A 4-entry input FIFO, with 2-bit pointers plus a wrap bit, is inserted ahead of the serialiser.
  - Data_Ready = FIFO not full.
  - The serialiser pops the head entry whenever it would otherwise accept a word.
  - Simultaneous push and pop when full: the push is accepted because the pop frees an entry that cycle.
  - Reset empties the FIFO.
  - Each FIFO entry stores only P_DATA; frame config is still latched at frame start.
- Undefined: no FIFO; Data_Ready follows the handshake rule above.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding typedef uart_tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - localparams IDLE_LEVEL=1'b1 and START_LEVEL=1'b0;
  - a parity function.
- One sub-module, uart_tx_fifo, is instantiated only under UART_TX_FIFO_EN. The serialiser FSM, bit counter and prescale counter stay in uart_tx_param.

Test Plan:
- Prescale=1, PAR_EN=0, STOP2=0, P_DATA=8'hF8, one-cycle Data_Valid.
  - Required: TX_OUT sequence 0,0,0,0,1,1,1,1,1,1 (10 bits, 1 clk each).
  - Required: busy=0 on cycle 11.
- Prescale=1, PAR_EN=1, PAR_TYP=0, P_DATA=8'h6F.
  - Required: TX_OUT sequence 0,1,1,1,1,0,1,1,0,0,1 (even parity bit 0).
  - Repeat with PAR_TYP=1: parity bit becomes 1.
- Prescale=4, STOP2=1, PAR_EN=0, P_DATA=8'h5D.
  - Required: every bit lasts exactly 4 clks.
  - Required: the line sequence is 0,1,0,1,1,1,0,1,0,1,1 (two stop bits), 44 clks total.
- Back-to-back, Prescale=1, PAR_EN=1, PAR_TYP=0: 8'h6F, then 8'h78 presented while Data_Ready is high in the last stop cycle.
  - Required: 22 contiguous bits with no idle gap.
  - Required: busy stays high throughout.
  - Required: the second frame's parity bit is 0.
- Assert RST=1 for one cycle in the middle of the DATA state.
  - Required: TX_OUT=1, busy=0, state IDLE on the next edge.
  - Required: the next valid word is transmitted correctly.
- UART_TX_FIFO_EN defined, Prescale=2: push 5 words on consecutive cycles.
  - Required: Data_Ready drops after 4 entries are held (the first word pops into the serialiser immediately).
  - Required: all words are transmitted in order, with no loss or duplication.
